// File: rtl/nand_exerciser.sv
// Clocked stimulus/check wrapper for a NAND path: sweeps a/b through 00,01,10,11,
// samples the returned value on the last hold cycle of each vector and counts mismatches.
module nand_exerciser #(
  parameter int HOLD_CYCLES = 4,
  parameter int PASSES      = 1,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a_out,
  output logic             b_out,
  input  logic             dut_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       vec_idx
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(PASSES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state_q,    state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [1:0]        vec_idx_q,  vec_idx_d;
  logic [ERR_W-1:0]  err_q,      err_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
  logic              pass_q,     pass_d;
  logic [ERR_W-1:0]  err_nxt_s;
  logic              mismatch_s;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    logic [ERR_W-1:0] r;
    if (v == {ERR_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + ERR_W'(1);
    end
    return r;
  endfunction

  assign a_out     = vec_idx_q[1];
  assign b_out     = vec_idx_q[0];
  assign vec_idx   = vec_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;

  // Expected NAND value comes straight from the registered vector being driven.
  assign mismatch_s = (dut_in != ~(vec_idx_q[1] & vec_idx_q[0]));
  assign err_nxt_s  = mismatch_s ? sat_inc(err_q) : err_q;

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    pass_cnt_d = pass_cnt_q;
    vec_idx_d  = vec_idx_q;
    err_d      = err_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_DRIVE;
          hold_cnt_d = {HOLD_W{1'b0}};
          pass_cnt_d = {PASS_W{1'b0}};
          vec_idx_d  = 2'd0;
          err_d      = {ERR_W{1'b0}};
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_DRIVE: begin
        if (hold_cnt_q == HOLD_LAST) begin
          hold_cnt_d = {HOLD_W{1'b0}};
          err_d      = err_nxt_s;
          vec_idx_d  = vec_idx_q + 2'd1;
          if (vec_idx_q == 2'd3) begin
            if (pass_cnt_q == PASS_LAST) begin
              state_d    = ST_DONE;
              pass_cnt_d = {PASS_W{1'b0}};
              vec_idx_d  = 2'd0;
              busy_d     = 1'b0;
              done_d     = 1'b1;
              pass_d     = (err_nxt_s == {ERR_W{1'b0}});
            end else begin
              pass_cnt_d = pass_cnt_q + PASS_W'(1);
            end
          end else begin
            pass_cnt_d = pass_cnt_q;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        hold_cnt_d = {HOLD_W{1'b0}};
        pass_cnt_d = {PASS_W{1'b0}};
        vec_idx_d  = 2'd0;
        err_d      = {ERR_W{1'b0}};
        busy_d     = 1'b0;
        done_d     = 1'b0;
        pass_d     = 1'b0;
      end
    endcase
  end

  // State and output registers; rst aborts any run without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= {HOLD_W{1'b0}};
      pass_cnt_q <= {PASS_W{1'b0}};
      vec_idx_q  <= 2'd0;
      err_q      <= {ERR_W{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      pass_cnt_q <= pass_cnt_d;
      vec_idx_q  <= vec_idx_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

endmodule

// File: tb/tb_nand_exerciser.sv
// Bench for nand_exerciser: four instances with different parameters, each fed
// by a selectable gate model (good NAND, stuck-at-1, AND, glitchy NAND).
`timescale 1ns/1ps
module tb_nand_exerciser;

  localparam int NI = 4;
  localparam int HOLD_P   [NI] = '{4, 4, 4, 1};
  localparam int PASSES_P [NI] = '{1, 3, 2, 1};
  localparam int ERR_W_P  [NI] = '{8, 8, 2, 8};

  localparam logic [1:0] M_GOOD  = 2'd0;
  localparam logic [1:0] M_ONE   = 2'd1;
  localparam logic [1:0] M_AND   = 2'd2;
  localparam logic [1:0] M_GLTCH = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_r  [NI];
  logic [1:0] mode_r   [NI];
  logic       glitch_r [NI];
  logic       dut_in_w [NI];
  logic       a_w      [NI];
  logic       b_w      [NI];
  logic       busy_w   [NI];
  logic       done_w   [NI];
  logic       pass_w   [NI];
  logic [7:0] err_w    [NI];
  logic [1:0] vec_w    [NI];

  int checks = 0;
  int failures = 0;

  typedef struct {
    int err;
    bit pass;
    int len;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    int         id;
    logic [1:0] md;
    int         exp_err;
    bit         hold_start;
  } vec_t;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int EW = ERR_W_P[g];
    logic [EW-1:0] e;
    logic a, b;
    assign dut_in_w[g] = (mode_r[g] == M_ONE) ? 1'b1 :
                         (mode_r[g] == M_AND) ? (a & b) :
                         (~(a & b) ^ glitch_r[g]);
    nand_exerciser #(
      .HOLD_CYCLES(HOLD_P[g]),
      .PASSES(PASSES_P[g]),
      .ERR_W(EW)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .start(start_r[g]),
      .a_out(a),
      .b_out(b),
      .dut_in(dut_in_w[g]),
      .busy(busy_w[g]),
      .done(done_w[g]),
      .pass(pass_w[g]),
      .err_count(e),
      .vec_idx(vec_w[g])
    );
    assign a_w[g]   = a;
    assign b_w[g]   = b;
    assign err_w[g] = 8'(e);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int outs(input int id);
    return {busy_w[id], done_w[id], pass_w[id], a_w[id], b_w[id], vec_w[id], err_w[id]};
  endfunction

  // One full run on instance id; expectation queued at start, popped at done.
  task automatic run(input int id, input logic [1:0] md, input int exp_err, input bit hold_start);
    int hold, len, budget, ev;
    exp_t e;
    hold   = HOLD_P[id];
    budget = 4 * hold * PASSES_P[id] + 8;
    mode_r[id]  = md;
    start_r[id] = 1'b1;
    sb_q.push_back('{err: exp_err, pass: (exp_err == 0), len: 4 * hold * PASSES_P[id]});
    tick();
    if (!hold_start) start_r[id] = 1'b0;
    len = 0;
    while (busy_w[id] && len < budget) begin
      ev = (len / hold) % 4;
      check($sformatf("u%0d vec_idx c%0d", id, len), vec_w[id], ev);
      check($sformatf("u%0d ab c%0d", id, len), {a_w[id], b_w[id]}, ev);
      check($sformatf("u%0d done_low c%0d", id, len), done_w[id], 0);
      glitch_r[id] = (md == M_GLTCH) && ((len % hold) != hold - 1);
      len++;
      tick();
    end
    glitch_r[id] = 1'b0;
    start_r[id]  = 1'b0;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      e = sb_q.pop_front();
      check($sformatf("u%0d run_len", id), len, e.len);
      check($sformatf("u%0d done", id), done_w[id], 1);
      check($sformatf("u%0d pass", id), pass_w[id], e.pass);
      check($sformatf("u%0d err_count", id), err_w[id], e.err);
      check($sformatf("u%0d idle_ab_vec", id), {a_w[id], b_w[id], vec_w[id]}, 0);
    end
    tick();
    check($sformatf("u%0d done_hold", id), {busy_w[id], done_w[id], err_w[id]},
          {1'b0, 1'b1, 8'(exp_err)});
  endtask

  vec_t tbl[$];

  initial begin
    for (int i = 0; i < NI; i++) begin
      start_r[i]  = 1'b0;
      mode_r[i]   = M_GOOD;
      glitch_r[i] = 1'b0;
    end
    tbl.push_back('{id: 0, md: M_GOOD,  exp_err: 0, hold_start: 1'b0});
    tbl.push_back('{id: 1, md: M_ONE,   exp_err: 3, hold_start: 1'b0});
    tbl.push_back('{id: 0, md: M_AND,   exp_err: 4, hold_start: 1'b0});
    tbl.push_back('{id: 0, md: M_GOOD,  exp_err: 0, hold_start: 1'b0});
    tbl.push_back('{id: 2, md: M_AND,   exp_err: 3, hold_start: 1'b0});
    tbl.push_back('{id: 3, md: M_GOOD,  exp_err: 0, hold_start: 1'b0});
    tbl.push_back('{id: 3, md: M_AND,   exp_err: 4, hold_start: 1'b0});
    tbl.push_back('{id: 3, md: M_ONE,   exp_err: 1, hold_start: 1'b0});
    tbl.push_back('{id: 0, md: M_GLTCH, exp_err: 0, hold_start: 1'b0});
    tbl.push_back('{id: 0, md: M_GOOD,  exp_err: 0, hold_start: 1'b1});
    tbl.push_back('{id: 1, md: M_AND,   exp_err: 12, hold_start: 1'b1});

    repeat (3) tick();
    for (int i = 0; i < NI; i++) check($sformatf("u%0d reset_state", i), outs(i), 0);

    // rst together with start: reset wins.
    start_r[0] = 1'b1;
    tick();
    check("rst_with_start", outs(0), 0);
    rst = 1'b0;
    start_r[0] = 1'b0;
    tick();
    check("idle_no_start", outs(0), 0);

    foreach (tbl[i]) run(tbl[i].id, tbl[i].md, tbl[i].exp_err, tbl[i].hold_start);

    // Reset mid-run at cycle 7 aborts with no done pulse.
    mode_r[0]  = M_AND;
    start_r[0] = 1'b1;
    tick();
    start_r[0] = 1'b0;
    repeat (6) tick();
    check("midrun_busy", {busy_w[0], vec_w[0]}, {1'b1, 2'd1});
    rst = 1'b1;
    tick();
    check("midrun_reset_state", outs(0), 0);
    rst = 1'b0;
    tick();
    check("after_reset_idle", outs(0), 0);
    run(0, M_GOOD, 0, 1'b0);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/nand_exerciser.md
Name: nand_exerciser

Overview:
- Sequential stimulus/check stage wrapped around the two-gate NAND path (AND followed by NOT).
- Upstream role: drives the NAND inputs a/b through all four input combinations.
- Downstream role: consumes the NAND output, compares each sample against the NAND truth table and counts mismatches.
- Replaces hand-timed initial-block stimulus with a clocked, repeatable self-check usable in sim and on board.

Parameters:
- HOLD_CYCLES, 4, clock cycles each input vector is held; output sampled on the last one; legal range >= 1.
- PASSES, 1, number of full 4-vector sweeps per run; legal range >= 1.
- ERR_W, 8, width of the mismatch counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a run; sampled only in IDLE or DONE
- a_out  output  1  drives NAND input a
- b_out  output  1  drives NAND input b
- dut_in  input  1  NAND output under test; may be combinational from a_out/b_out
- busy  output  1  high while vectors are being driven
- done  output  1  high in DONE until the next start or reset
- pass  output  1  valid when done=1; 1 iff err_count==0
- err_count  output  ERR_W  saturating mismatch count
- vec_idx  output  2  current vector index; a_out=vec_idx[1], b_out=vec_idx[0]

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - Reset is synchronous, active-high, on rst.
- All outputs are registered. Reset values:
  - a_out=0, b_out=0, vec_idx=0
  - busy=0, done=0, pass=0, err_count=0
  - FSM=IDLE, hold and pass counters at 0
- rst overrides every other input on the same edge. rst mid-run aborts the run immediately, with no done pulse.
- FSM states: IDLE, DRIVE, DONE.
- IDLE:
  - start=1 at edge k -> DRIVE; busy=1, vec_idx=0, err_count=0, counters=0, all from cycle k+1.
  - start=0 -> stay in IDLE.
- DRIVE:
  - Vector order: 00, 01, 10, 11.
  - Expected value = ~(a_out & b_out), i.e. 1,1,1,0.
  - hold_cnt counts 0..HOLD_CYCLES-1 per vector.
  - On the cycle where hold_cnt==HOLD_CYCLES-1:
    - dut_in is compared against the expected value.
    - A mismatch increments err_count, saturating at 2^ERR_W-1 (never wraps).
    - hold_cnt resets to 0 and vec_idx advances.
  - vec_idx wraps 3 -> 0 and pass_cnt increments.
  - After the compare of vector 11 on pass PASSES-1 -> DONE.
  - start is ignored in DRIVE.
  - Run length: exactly 4*HOLD_CYCLES*PASSES cycles with busy=1.
  - HOLD_CYCLES=1: every DRIVE cycle is a compare cycle.
- DONE:
  - busy=0, done=1, pass=(err_count==0).
  - a_out/b_out return to 0 and vec_idx=0.
  - err_count holds.
  - start=1 -> DRIVE on the next edge: done=0, pass=0, err_count cleared. This is identical to a start from IDLE.
- Compare timing: only the final hold cycle is sampled. Glitches or settling on earlier cycles of a vector are not errors.
- Simultaneous events:
  - Saturated counter plus mismatch -> stays at maximum.
  - rst together with start -> reset wins.

Test Plan:
- Good NAND, HOLD_CYCLES=4, PASSES=1, dut_in=~(a_out&b_out): start pulse at cycle 0 -> busy high cycles 1-16, a/b sequence 00,01,10,11 with 4 cycles each; done=1, pass=1, err_count=0 at cycle 17.
- Stuck-at-1 output (dut_in=1), PASSES=3 -> err_count=3 (only vector 11 fails), pass=0; busy high for 48 cycles.
- AND without the NOT (dut_in=a_out&b_out), PASSES=1 -> err_count=4, pass=0.
- Saturation, ERR_W=2, PASSES=2, AND gate -> 8 mismatches but err_count=3 at done; no wrap to 0.
- Reset mid-run: rst at cycle 7 of a run -> next cycle all outputs at reset values, FSM=IDLE; a new start then completes a clean 16-cycle run with pass=1.
- start held high during DRIVE -> no restart, run length unchanged. From DONE, a start with the good NAND after a failed run -> err_count cleared to 0, then pass=1.
